pipe_stage_elastic: RTL and testbench
=====================================

PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 Parameter: DATA_W, 64, payload width in bits (PC plus instruction for the IF/ID use).
REQ-002 Parameter: FLUSH_VAL, all zeros (DATA_W bits), value driven on out_data after reset or flush.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous squash of all held entries.
REQ-006 in_valid  input  1  upstream payload valid.
REQ-007 in_ready  output  1  stage can accept a payload this cycle.
REQ-008 in_data  input  DATA_W  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid payload.
REQ-010 out_ready  input  1  downstream accepts this cycle.
REQ-011 out_data  output  DATA_W  payload to downstream.
REQ-012 occupancy  output  2  entries held (0..2).

Function
REQ-013 Push SHALL occur when in_valid and in_ready are both high; pop SHALL occur when out_valid and out_ready are both high.
REQ-014 State machine SHALL have EMPTY (0 entries), BUSY (1 entry, main register), FULL (2 entries, main plus skid).
REQ-015 EMPTY: push -> BUSY with main<=in_data; else stay; out_valid=0.
REQ-016 BUSY: push and pop -> BUSY with main<=in_data; pop only -> EMPTY; push only -> FULL with skid<=in_data; neither -> stay.
REQ-017 FULL: pop -> BUSY with main<=skid; no push possible; else stay.
REQ-018 Latency in->out SHALL be exactly 1 cycle when the stage is EMPTY or popping.
REQ-019 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-020 out_valid SHALL equal (state != EMPTY); occupancy SHALL equal 0/1/2 for EMPTY/BUSY/FULL.
REQ-021 Flush SHALL have priority over push and pop: next state EMPTY, main<=FLUSH_VAL, skid discarded.
REQ-022 in_ready SHALL be low during a flush cycle, so any in_valid payload in that cycle is dropped.
REQ-023 Order SHALL be preserved: the skid entry never overtakes the main entry.
REQ-024 Sustained in_valid=1 with out_ready=1 SHALL give one pop per cycle with no bubbles.

Reset
REQ-025 rst low SHALL asynchronously force state EMPTY, main=FLUSH_VAL, skid=FLUSH_VAL, out_valid=0, occupancy=0, in_ready=0.
REQ-026 in_ready SHALL rise in the first clock cycle after rst deasserts.
REQ-027 Reset mid-transfer SHALL discard all entries with no partial pop.

Configuration
REQ-028 Macro PIPE_STAGE_ELASTIC_SKID_EN defined: full FSM (REQ-014..017); in_ready SHALL be registered, equal to (next state != FULL), and have no combinational path from out_ready.
REQ-029 Macro PIPE_STAGE_ELASTIC_SKID_EN undefined: no skid register; states EMPTY and BUSY only; in_ready = !flush and (!out_valid or out_ready), combinational; occupancy max 1.

Structure
REQ-030 Shared package pipe_pkg SHALL hold the state encoding (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10) and the constant IF_ID_W=64.
REQ-031 One sub-module, pipe_data_reg, SHALL be used: a DATA_W load-enable register with synchronous clear to FLUSH_VAL and asynchronous reset. It SHALL be instantiated for main and skid.

Verification
REQ-032 Reset then push 0x1234 with out_ready=1 -> out_valid=1, out_data=0x1234 the next cycle, occupancy=1.
REQ-033 out_ready=0, push A then B (SKID_EN) -> occupancy=2 and in_ready=0 the next cycle. Then out_ready=1 -> A, then B, on consecutive cycles.
REQ-034 Stream 100 payloads with in_valid=1 and out_ready=1 -> 100 pops in 100 consecutive cycles, in order.
REQ-035 FULL with flush=1 and in_valid=1 (data 0xDEAD) -> next cycle out_valid=0, occupancy=0, out_data=FLUSH_VAL; 0xDEAD is never popped.
REQ-036 rst asserted low mid-cycle in BUSY -> out_valid drops immediately without waiting for a clock edge; after release the first push appears 1 cycle later.
REQ-037 SKID_EN undefined: out_ready=0 while BUSY -> in_ready=0 in the same cycle; toggling out_ready to 1 -> in_ready=1 in the same cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: FSM state encoding and
// the IF/ID payload width.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    localparam int IF_ID_W = 64;

endpackage

// File: rtl/pipe_data_reg.sv
// Load-enable payload register with synchronous clear to FLUSH_VAL and
// asynchronous active-low reset to the same value.
module pipe_data_reg #(
    parameter int                 DATA_W    = 64,
    parameter logic [DATA_W-1:0]  FLUSH_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Clear wins over load so a squash never lets a same-cycle payload in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= FLUSH_VAL;
        end else if (clear) begin
            q <= FLUSH_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage (EMPTY/BUSY/FULL). Define
// PIPE_STAGE_ELASTIC_SKID_EN for the skid-buffered variant with registered in_ready.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid never depends on ready, and out_data holds while out_valid && !out_ready.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = IF_ID_W,
    parameter logic [DATA_W-1:0] FLUSH_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [1:0]        dbg_state
);

    state_t            state;
    state_t            state_nxt;
    logic              push;
    logic              pop;
    logic              main_load;
    logic [DATA_W-1:0] main_d;

    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_valid = (state != EMPTY);
    assign occupancy = state;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    pipe_data_reg #(.DATA_W(DATA_W), .FLUSH_VAL(FLUSH_VAL)) u_main (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .load  (main_load),
        .d     (main_d),
        .q     (out_data)
    );

`ifdef PIPE_STAGE_ELASTIC_SKID_EN
    logic              skid_load;
    logic [DATA_W-1:0] skid_q;
    logic              in_ready_q;

    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        skid_load = 1'b0;
        main_d    = in_data;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (push) begin
                    state_nxt = BUSY;
                    main_load = 1'b1;
                end
                BUSY: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end else if (push) begin
                        state_nxt = FULL;
                        skid_load = 1'b1;
                    end
                end
                FULL: if (pop) begin
                    state_nxt = BUSY;
                    main_load = 1'b1;
                    main_d    = skid_q;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Ready is decided a cycle ahead from the next state, so out_ready never
    // reaches in_ready combinationally; flush still masks it in its own cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_q <= 1'b0;
        end else begin
            in_ready_q <= (state_nxt != FULL);
        end
    end

    assign in_ready = in_ready_q && !flush;

    pipe_data_reg #(.DATA_W(DATA_W), .FLUSH_VAL(FLUSH_VAL)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .load  (skid_load),
        .d     (in_data),
        .q     (skid_q)
    );
`else
    // Without a skid slot the stage can only take a payload if it drains this cycle.
    assign in_ready = rst && !flush && (!out_valid || out_ready);

    always_comb begin
        state_nxt = state;
        main_load = 1'b0;
        main_d    = in_data;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (push) begin
                    state_nxt = BUSY;
                    main_load = 1'b1;
                end
                BUSY: begin
                    if (push) begin
                        main_load = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic; covers both the default build and
// the PIPE_STAGE_ELASTIC_SKID_EN build.
module tb_pipe_stage_elastic;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;
    logic [1:0]   dbg_state;

    logic [W-1:0] exp_q[$];
    int           total = 0;
    int           bad   = 0;
    int           pop_cnt = 0;

    pipe_stage_elastic #(.DATA_W(W), .FLUSH_VAL('0)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
    endtask

    // scoreboard: payloads accepted upstream must emerge downstream in order
    always @(negedge clk) begin
        if (!rst || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) check("pop_unexpected_qsize", W'(exp_q.size()), W'(1));
                else check("pop_data", out_data, exp_q.pop_front());
            end
            if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    initial begin
        int pc0;
        int bubbles;
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, '0, 1'b0);

        // reset state
        #2;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_occupancy", W'(occupancy), W'(0));
        check("rst_in_ready", W'(in_ready), W'(0));
        check("rst_out_data", out_data, '0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_in_ready", W'(in_ready), W'(1));

        // single payload, one-cycle latency
        drive(1'b1, 64'h1234, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        #1;
        check("lat_out_valid", W'(out_valid), W'(1));
        check("lat_out_data", out_data, 64'h1234);
        check("lat_occupancy", W'(occupancy), W'(1));
        tick();
        check("drain_occupancy", W'(occupancy), W'(0));

`ifdef PIPE_STAGE_ELASTIC_SKID_EN
        // fill main and skid while downstream stalls
        drive(1'b1, 64'hAAAA_0001, 1'b0);
        tick();
        drive(1'b1, 64'hBBBB_0002, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0);
        #1;
        check("full_occupancy", W'(occupancy), W'(2));
        check("full_in_ready", W'(in_ready), W'(0));
        check("full_out_data", out_data, 64'hAAAA_0001);
        tick();
        check("full_hold_data", out_data, 64'hAAAA_0001);
        out_ready = 1'b1;
        tick();
        check("skid_to_main_data", out_data, 64'hBBBB_0002);
        check("skid_to_main_occ", W'(occupancy), W'(1));
        tick();
        check("skid_drain_occ", W'(occupancy), W'(0));
`else
        // stall: ready follows out_ready combinationally
        drive(1'b1, 64'hA5A5_5A5A, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0);
        #1;
        check("stall_in_ready", W'(in_ready), W'(0));
        check("stall_occupancy", W'(occupancy), W'(1));
        tick();
        check("stall_hold_data", out_data, 64'hA5A5_5A5A);
        out_ready = 1'b1;
        #1;
        check("unstall_in_ready", W'(in_ready), W'(1));
        tick();
        check("unstall_occupancy", W'(occupancy), W'(0));
`endif

        // sustained streaming: 100 pops, no bubbles
        pc0     = pop_cnt;
        bubbles = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, {$urandom, $urandom}, 1'b1);
            if (i > 0 && !out_valid) bubbles++;
            tick();
        end
        drive(1'b0, '0, 1'b1);
        tick();
        check("stream_pops", W'(pop_cnt - pc0), W'(100));
        check("stream_bubbles", W'(bubbles), W'(0));
        check("stream_occupancy", W'(occupancy), W'(0));

        // flush while holding data, with a competing payload
        drive(1'b1, 64'hC0C0_0003, 1'b0);
        tick();
`ifdef PIPE_STAGE_ELASTIC_SKID_EN
        drive(1'b1, 64'hD0D0_0004, 1'b0);
        tick();
        check("pre_flush_occ", W'(occupancy), W'(2));
`else
        check("pre_flush_occ", W'(occupancy), W'(1));
`endif
        flush = 1'b1;
        drive(1'b1, 64'hDEAD, 1'b0);
        #1;
        check("flush_in_ready", W'(in_ready), W'(0));
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 1'b0);
        #1;
        check("flush_out_valid", W'(out_valid), W'(0));
        check("flush_occupancy", W'(occupancy), W'(0));
        check("flush_out_data", out_data, '0);
        out_ready = 1'b1;
        tick();
        tick();

        // flush from EMPTY must also refuse the payload
        flush = 1'b1;
        drive(1'b1, 64'hDEAD, 1'b1);
        #1;
        check("flush_empty_in_ready", W'(in_ready), W'(0));
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 1'b1);
        #1;
        check("flush_empty_out_valid", W'(out_valid), W'(0));

        // asynchronous reset in BUSY
        drive(1'b1, 64'h77, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0);
        #1;
        check("pre_rst_out_valid", W'(out_valid), W'(1));
        rst = 1'b0;
        #1;
        check("async_rst_out_valid", W'(out_valid), W'(0));
        check("async_rst_occupancy", W'(occupancy), W'(0));
        check("async_rst_in_ready", W'(in_ready), W'(0));
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rerst_in_ready", W'(in_ready), W'(1));
        drive(1'b1, 64'h99, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1);
        #1;
        check("rerst_out_valid", W'(out_valid), W'(1));
        check("rerst_out_data", out_data, 64'h99);
        tick();
        tick();

        check("queue_empty_at_end", W'(exp_q.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
